// File: rtl/dvp_pattern_source.sv
// OV7670-style DVP transmitter in RGB565 mode, producing synthetic test frames
// (colour bars, x ramp, y/x mix, solid red) for exercising the capture path.
module dvp_pattern_source #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern,
    output logic        cmos_pclk,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_db,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int L  = 2 * (H_ACTIVE + H_BLANK);
    localparam int CW = $clog2(L);
    localparam int LW = $clog2(VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
    localparam logic [CW-1:0] COL_HREF = CW'(2 * H_ACTIVE);
    localparam logic [15:0]   BAR_W    = 16'(H_ACTIVE / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBP    = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFP    = 3'd4;

    logic [2:0]    st, nst;
    logic [CW-1:0] col, ncol;
    logic [LW-1:0] line, nline, last_line;
    logic [1:0]    pat, npat;
    logic          wrap;
    logic          href_n;
    logic [15:0]   xv, pix;
    logic [7:0]    y8;
    logic [2:0]    bar;
    logic [7:0]    byte_n;

    // Position (st, col, line) describes the pclk period currently on the bus;
    // the n* values are the period that starts at the next fall edge.
    always_comb begin
        nst   = st;
        ncol  = col;
        nline = line;
        npat  = pat;
        wrap  = 1'b0;
        case (st)
            S_VSYNC:  last_line = LW'(VS_LINES - 1);
            S_VBP:    last_line = LW'(VBP_LINES - 1);
            S_ACTIVE: last_line = LW'(V_ACTIVE - 1);
            default:  last_line = LW'(VFP_LINES - 1);
        endcase
        if (st == S_IDLE) begin
            if (en) begin
                nst   = S_VSYNC;
                ncol  = '0;
                nline = '0;
                npat  = pattern;
            end
        end else if (col != COL_LAST) begin
            ncol = col + 1'b1;
        end else begin
            ncol = '0;
            if (line != last_line) begin
                nline = line + 1'b1;
            end else begin
                nline = '0;
                case (st)
                    S_VSYNC:  nst = S_VBP;
                    S_VBP:    nst = S_ACTIVE;
                    S_ACTIVE: nst = S_VFP;
                    default: begin
                        wrap = 1'b1;
                        if (en) begin
                            nst  = S_VSYNC;
                            npat = pattern;
                        end else begin
                            nst = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        xv     = 16'(ncol >> 1);
        y8     = 8'(nline);
        bar    = 3'(xv / BAR_W);
        href_n = (nst == S_ACTIVE) && (ncol < COL_HREF);
        case (npat)
            2'd0: begin
                case (bar)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = xv;
            2'd2:    pix = {y8, xv[7:0]};
            default: pix = 16'hF800;
        endcase
        byte_n = ncol[0] ? pix[7:0] : pix[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmos_pclk  <= 1'b0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_db    <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            st         <= S_IDLE;
            col        <= '0;
            line       <= '0;
            pat        <= 2'd0;
        end else begin
            cmos_pclk  <= ~cmos_pclk;
            frame_done <= 1'b0;
            // pclk is high now, so this edge is a fall edge
            if (cmos_pclk) begin
                st         <= nst;
                col        <= ncol;
                line       <= nline;
                pat        <= npat;
                cmos_vsync <= (nst == S_VSYNC);
                cmos_href  <= href_n;
                cmos_db    <= href_n ? byte_n : 8'h00;
                if (wrap) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Bench for dvp_pattern_source with a reduced frame geometry: pclk-rise
// scoreboard plus a table of hand-computed pixel bytes.
module tb_dvp_pattern_source;

    localparam int HA  = 32;
    localparam int HB  = 8;
    localparam int VA  = 6;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int VFP = 1;
    localparam int L   = 2 * (HA + HB);

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern;
    logic        cmos_pclk, cmos_vsync, cmos_href, frame_done;
    logic [7:0]  cmos_db;
    logic [15:0] frame_cnt;

    dvp_pattern_source #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern),
        .cmos_pclk(cmos_pclk), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cmos_db(cmos_db),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int p, input int x, input int y);
        logic [15:0] xs, ys;
        xs = 16'(x);
        ys = 16'(y);
        case (p)
            0: begin
                case (x / (HA / 8))
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1:       return xs;
            2:       return {ys[7:0], xs[7:0]};
            default: return 16'hF800;
        endcase
    endfunction

    // scoreboard state
    bit         mon_en = 0;
    bit         prev_vs = 0, prev_href = 0, in_gap = 0;
    int         vs_run = 0, gap_run = 0, href_run = 0, low_run = 0;
    int         mon_y = 0, b = 0, cur_pat = 0, fd_seen = 0;
    logic [7:0] cap [4][8][64];
    logic [15:0] ep;
    logic [7:0]  eb;

    always @(negedge clk) begin
        if (frame_done) fd_seen++;
        if (mon_en && cmos_pclk) begin
            chk("vs_href_excl", 32'(cmos_vsync & cmos_href), 0);
            if (cmos_vsync && !prev_vs) begin
                cur_pat = int'(pattern);
                mon_y   = 0;
                vs_run  = 0;
            end
            if (cmos_vsync) vs_run++;
            if (!cmos_vsync && prev_vs) begin
                chk("vsync_width", vs_run, VS * L);
                in_gap  = 1;
                gap_run = 0;
            end
            if (prev_href && !cmos_href) begin
                chk("href_width", href_run, 2 * HA);
                mon_y++;
                low_run = 0;
            end
            if (cmos_href && !prev_href) begin
                if (in_gap) begin
                    chk("vbp_gap", gap_run, VBP * L);
                    in_gap = 0;
                end else begin
                    chk("hblank_gap", low_run, 2 * HB);
                end
                href_run = 0;
                b        = 0;
            end
            if (cmos_href) begin
                ep = pix(cur_pat, b / 2, mon_y);
                eb = (b % 2 == 1) ? ep[7:0] : ep[15:8];
                chk("db_pixel", 32'(cmos_db), 32'(eb));
                if (mon_y < 8 && b < 64) cap[cur_pat][mon_y][b] = cmos_db;
                href_run++;
                b++;
            end else begin
                chk("db_blank", 32'(cmos_db), 0);
                low_run++;
                if (in_gap && !cmos_vsync) gap_run++;
            end
            prev_vs   = cmos_vsync;
            prev_href = cmos_href;
        end
    end

    task automatic wait_fd();
        int t = 0;
        while (!frame_done && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_seen", 32'(t < 4000), 1);
    endtask

    task automatic wait_line(input int n);
        int t = 0;
        while (!(mon_y == n && cmos_href) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("line_reached", 32'(t < 5000), 1);
    endtask

    task automatic idle_check(input string nm, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (cmos_vsync || cmos_href || cmos_db != 8'h00 || frame_done)
                bad++;
        end
        chk(nm, bad, 0);
    endtask

    typedef struct {
        int         pat;
        int         y;
        int         bi;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{0, 0, 0,  8'hFF};
        tbl[1]  = '{0, 0, 1,  8'hFF};
        tbl[2]  = '{0, 0, 8,  8'hFF};
        tbl[3]  = '{0, 0, 9,  8'hE0};
        tbl[4]  = '{0, 3, 20, 8'h07};
        tbl[5]  = '{0, 3, 21, 8'hFF};
        tbl[6]  = '{0, 0, 24, 8'h07};
        tbl[7]  = '{0, 0, 25, 8'hE0};
        tbl[8]  = '{0, 1, 33, 8'h1F};
        tbl[9]  = '{0, 2, 48, 8'h00};
        tbl[10] = '{0, 2, 49, 8'h1F};
        tbl[11] = '{0, 5, 62, 8'h00};
        tbl[12] = '{0, 5, 63, 8'h00};
        tbl[13] = '{2, 5, 40, 8'h05};
        tbl[14] = '{2, 5, 41, 8'h14};
        tbl[15] = '{1, 2, 38, 8'h00};
        tbl[16] = '{1, 2, 39, 8'h13};
        tbl[17] = '{3, 1, 30, 8'hF8};
        for (int p = 0; p < 4; p++)
            for (int y = 0; y < 8; y++)
                for (int i = 0; i < 64; i++)
                    cap[p][y][i] = 8'h5A;

        rst = 1'b1;
        en = 1'b0;
        pattern = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            32'({cmos_pclk, cmos_vsync, cmos_href, cmos_db, frame_done}), 0);
        chk("reset_frame_cnt", 32'(frame_cnt), 0);

        rst = 1'b0;
        en = 1'b1;
        mon_en = 1;

        // pattern changes land mid-frame and must wait for the next vsync
        wait_line(2);
        pattern = 2'd2;
        wait_fd();
        chk("frame_cnt_1", 32'(frame_cnt), 1);
        chk("lines_frame_1", mon_y, VA);

        wait_line(2);
        pattern = 2'd1;
        wait_fd();
        chk("frame_cnt_2", 32'(frame_cnt), 2);

        wait_line(2);
        pattern = 2'd3;
        wait_fd();
        chk("frame_cnt_3", 32'(frame_cnt), 3);

        wait_line(3);
        en = 1'b0;
        wait_fd();
        chk("frame_cnt_4", 32'(frame_cnt), 4);
        chk("lines_frame_4", mon_y, VA);
        idle_check("idle_quiet", 4 * L);
        chk("frame_cnt_idle", 32'(frame_cnt), 4);
        chk("frame_done_pulses", fd_seen, 4);

        for (int i = 0; i < 18; i++)
            chk($sformatf("tbl%0d_p%0d_y%0d_b%0d", i, tbl[i].pat, tbl[i].y, tbl[i].bi),
                32'(cap[tbl[i].pat][tbl[i].y][tbl[i].bi]), 32'(tbl[i].exp));

        // reset in the middle of an active line
        en = 1'b1;
        wait_line(1);
        mon_en = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_outputs",
            32'({cmos_pclk, cmos_vsync, cmos_href, cmos_db, frame_done}), 0);
        chk("midframe_rst_frame_cnt", 32'(frame_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("pclk_after_rst_1", 32'(cmos_pclk), 1);
        @(negedge clk);
        chk("pclk_after_rst_0", 32'(cmos_pclk), 0);
        idle_check("idle_after_rst", 2 * L);
        chk("frame_cnt_after_rst", 32'(frame_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
